// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 keyboard receiver constants, RX state enum and helpers
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    localparam int KEY_TOGGLE = 10;
    localparam int KEY_PRESS  = 9;
    localparam int KEY_EXT    = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Keyboard status/response bytes that never describe a key event
    function automatic logic is_discard(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// rtl/ps2_key_rx_if.sv - PS/2 pin inputs and decoded key word outputs
interface ps2_key_rx_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (input ps2_clk, input ps2_data, output ps2_key, output frame_err);
    modport slave  (output ps2_clk, output ps2_data, input ps2_key, input frame_err);
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronisers, optional deglitch (PS2_RX_DEGLITCH_EN), clock fedge
module ps2_line_sync #(
    parameter int FILT_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_s,
    output logic fedge
);

    // bit 0 carries the clock line, bit 1 the data line; idle-high reset avoids a false edge
    logic [1:0] meta;
    logic [1:0] sync;
    logic [1:0] line;
    logic       clk_prev;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 2'b11;
            sync <= 2'b11;
        end else begin
            meta <= {ps2_data, ps2_clk};
            sync <= meta;
        end
    end

`ifdef PS2_RX_DEGLITCH_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    logic [1:0]    filt;
    logic [CW-1:0] cnt [2];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt   <= 2'b11;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= sync[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign line = filt;
`else
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN > 0);
    assign line = sync;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) clk_prev <= 1'b1;
        else          clk_prev <= line[0];
    end

    assign data_s = line[1];
    assign fedge  = clk_prev & ~line[0];

endmodule

// File: rtl/ps2_key_rx.sv
// rtl/ps2_key_rx.sv - PS/2 keyboard frame receiver and E0/F0/E1 prefix decoder (PS2_RX_DEGLITCH_EN)
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILT_LEN    = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    ps2_key_rx_if.master     bus
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    logic            data_s;
    logic            fedge;
    rx_state_t       state, state_next;
    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            timeout;
    logic            stop_ok;
    logic            accept;
    logic            reject;
    logic            ext, rel;
    logic [2:0]      skip_cnt;
    logic [10:0]     key_q;
    logic            err_q;

    ps2_line_sync #(.FILT_LEN(FILT_LEN)) u_sync (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .data_s   (data_s),
        .fedge    (fedge)
    );

    // A falling edge in the same cycle as expiry keeps the frame alive
    assign timeout = (state != RX_IDLE) && !fedge && (wd_cnt == WD_LAST);
    assign stop_ok = data_s && (^{shreg, par_bit});
    assign accept  = fedge && (state == RX_STOP) && stop_ok;
    assign reject  = fedge && (state == RX_STOP) && !stop_ok;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= RX_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (timeout) begin
            state_next = RX_IDLE;
        end else if (fedge) begin
            case (state)
                RX_IDLE:   if (!data_s) state_next = RX_DATA;
                RX_DATA:   if (bitcnt == 3'd7) state_next = RX_PARITY;
                RX_PARITY: state_next = RX_STOP;
                default:   state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bitcnt   <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            wd_cnt   <= '0;
            ext      <= 1'b0;
            rel      <= 1'b0;
            skip_cnt <= '0;
            key_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;

            if (fedge || state == RX_IDLE || timeout) wd_cnt <= '0;
            else                                      wd_cnt <= wd_cnt + WD_W'(1);

            if (fedge) begin
                case (state)
                    RX_IDLE:   bitcnt <= '0;
                    RX_DATA: begin
                        shreg  <= {data_s, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                    end
                    RX_PARITY: par_bit <= data_s;
                    default:   ;
                endcase
            end

            if (timeout || reject) begin
                err_q <= 1'b1;
                ext   <= 1'b0;
                rel   <= 1'b0;
            end

            if (accept) begin
                if (skip_cnt != 3'd0) begin
                    skip_cnt <= skip_cnt - 3'd1;
                end else if (shreg == PS2_PAUSE) begin
                    skip_cnt <= 3'd7;
                    ext      <= 1'b0;
                    rel      <= 1'b0;
                end else if (shreg == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (shreg == PS2_BRK) begin
                    rel <= 1'b1;
                end else begin
                    if (!is_discard(shreg)) begin
                        key_q <= {~key_q[KEY_TOGGLE], ~rel, ext, shreg};
                    end
                    ext <= 1'b0;
                    rel <= 1'b0;
                end
            end
        end
    end

    assign bus.ps2_key   = key_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// tb/tb_ps2_key_rx.sv - table-driven scoreboard bench for ps2_key_rx
module tb_ps2_key_rx;

    localparam int TO   = 300;
    localparam int HALF = 10;
    localparam int NROW = 26;

    typedef struct {
        logic [7:0]  code;
        bit          par_ok;
        bit          stop;
        bit          emit;
        logic [10:0] key;
        int          err;
        bit          tmo;
    } row_t;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    ps2_key_rx_if bus ();

    ps2_key_rx #(.TIMEOUT_CYC(TO), .FILT_LEN(4)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          err_cnt  = 0;
    int          err_run  = 0;
    logic [10:0] exp_q [$];
    logic [10:0] last_key = '0;
    row_t        rows [NROW];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            last_key = bus.ps2_key;
            err_run  = 0;
        end else begin
            if (bus.ps2_key !== last_key) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL key_unexpected got=%h expected=no_change", bus.ps2_key);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    if (bus.ps2_key !== e) begin
                        failures++;
                        $display("FAIL key_value got=%h expected=%h", bus.ps2_key, e);
                    end
                end
                last_key = bus.ps2_key;
            end
            if (bus.frame_err === 1'b1) begin
                if (err_run == 0) err_cnt++;
                err_run++;
            end else begin
                if (err_run != 0) chk("err_width", err_run, 1);
                err_run = 0;
            end
        end
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk_sys);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk_sys);
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_sys);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit par_ok, input bit stop,
                              input bit emit, input logic [10:0] key_before,
                              input logic [10:0] key_after);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par_ok ? ~^code : ^code);
        @(negedge clk_sys);
        bus.ps2_data = stop;
        repeat (HALF) @(negedge clk_sys);
        bus.ps2_clk = 1'b0;
        repeat (2) @(negedge clk_sys);
`ifndef PS2_RX_DEGLITCH_EN
        if (emit) chk("lat_early", bus.ps2_key, key_before);
`endif
        @(negedge clk_sys);
`ifndef PS2_RX_DEGLITCH_EN
        if (emit) chk("lat_on", bus.ps2_key, key_after);
`endif
        repeat (HALF - 3) @(negedge clk_sys);
        bus.ps2_clk = 1'b1;
    endtask

    initial begin
        logic [10:0] model_key;
        int          e0;
        #20ms;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [10:0] model_key;
        int          e0;

        rows[0]  = '{8'h1C, 1, 1, 1, 11'h61C, 0, 0};
        rows[1]  = '{8'hF0, 1, 1, 0, 11'h000, 0, 0};
        rows[2]  = '{8'h1C, 1, 1, 1, 11'h01C, 0, 0};
        rows[3]  = '{8'hE0, 1, 1, 0, 11'h000, 0, 0};
        rows[4]  = '{8'h75, 1, 1, 1, 11'h775, 0, 0};
        rows[5]  = '{8'hE0, 1, 1, 0, 11'h000, 0, 0};
        rows[6]  = '{8'hF0, 1, 1, 0, 11'h000, 0, 0};
        rows[7]  = '{8'h75, 1, 1, 1, 11'h175, 0, 0};
        rows[8]  = '{8'h29, 0, 1, 0, 11'h000, 1, 0};
        rows[9]  = '{8'h29, 1, 1, 1, 11'h629, 0, 0};
        rows[10] = '{8'h16, 1, 1, 1, 11'h216, 0, 1};
        rows[11] = '{8'hE1, 1, 1, 0, 11'h000, 0, 0};
        rows[12] = '{8'h14, 1, 1, 0, 11'h000, 0, 0};
        rows[13] = '{8'h77, 1, 1, 0, 11'h000, 0, 0};
        rows[14] = '{8'hE1, 1, 1, 0, 11'h000, 0, 0};
        rows[15] = '{8'hF0, 1, 1, 0, 11'h000, 0, 0};
        rows[16] = '{8'h14, 1, 1, 0, 11'h000, 0, 0};
        rows[17] = '{8'hF0, 1, 1, 0, 11'h000, 0, 0};
        rows[18] = '{8'h77, 1, 1, 0, 11'h000, 0, 0};
        rows[19] = '{8'h05, 1, 1, 1, 11'h605, 0, 0};
        rows[20] = '{8'hE0, 1, 1, 0, 11'h000, 0, 0};
        rows[21] = '{8'h75, 1, 0, 0, 11'h000, 1, 0};
        rows[22] = '{8'h75, 1, 1, 1, 11'h275, 0, 0};
        rows[23] = '{8'hE0, 1, 1, 0, 11'h000, 0, 0};
        rows[24] = '{8'hAA, 1, 1, 0, 11'h000, 0, 0};
        rows[25] = '{8'h1C, 1, 1, 1, 11'h61C, 0, 0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset_n      = 1'b0;
        repeat (5) @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("reset_key", bus.ps2_key, 11'h000);
        chk("reset_err", bus.frame_err, 1'b0);
        model_key = 11'h000;

        for (int r = 0; r < NROW; r++) begin
            if (rows[r].tmo) begin
                e0 = err_cnt;
                ps2_bit(1'b0);
                for (int i = 0; i < 5; i++) ps2_bit(i[0]);
                repeat (TO - 20) @(negedge clk_sys);
                chk("tmo_early", err_cnt, e0);
                repeat (40) @(negedge clk_sys);
                chk("tmo_err", err_cnt, e0 + 1);
            end
            e0 = err_cnt;
            if (rows[r].emit) exp_q.push_back(rows[r].key);
            send_frame(rows[r].code, rows[r].par_ok, rows[r].stop, rows[r].emit,
                       model_key, rows[r].key);
            repeat (3) @(negedge clk_sys);
            chk($sformatf("row%0d_err", r), err_cnt, e0 + rows[r].err);
            if (rows[r].emit) model_key = rows[r].key;
        end

        // reset in the middle of a frame: no frame_err, key cleared, receiver restarts clean
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("midrst_key", bus.ps2_key, 11'h000);
        chk("midrst_err", bus.frame_err, 1'b0);
        reset_n = 1'b1;
        repeat (TO + 20) @(negedge clk_sys);
        chk("midrst_noerr", err_cnt, e0);
        exp_q.push_back(11'h61C);
        send_frame(8'h1C, 1, 1, 1, 11'h000, 11'h61C);
        repeat (10) @(negedge clk_sys);
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
